dmem_arbiter: RTL and testbench

Two-master arbiter that shares the single data-memory/LSU port of the RV32I core between the CPU load/store path (master 0) and a debug/program-loader port (master 1). Grants one access per cycle with round-robin priority on ties. Tracks a single outstanding read for a fixed downstream read latency and routes the returned data to the master that issued it. Sits between the core/debug logic and the `lsu` instance.

---
 rtl/dmem_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter for the shared data-memory port with a single outstanding read.
// Optional stall counters are built only when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_m0_req,
    input  logic             i_m1_req,
    input  logic             i_m0_we,
    input  logic             i_m1_we,
    input  logic [31:0]      i_m0_addr,
    input  logic [31:0]      i_m1_addr,
    input  logic [31:0]      i_m0_wdata,
    input  logic [31:0]      i_m1_wdata,
    input  logic [3:0]       i_m0_be,
    input  logic [3:0]       i_m1_be,
    output logic             o_m0_gnt,
    output logic             o_m1_gnt,
    output logic             o_m0_rvalid,
    output logic             o_m1_rvalid,
    output logic [31:0]      o_m0_rdata,
    output logic [31:0]      o_m1_rdata,
    output logic             o_s_re,
    output logic             o_s_we,
    output logic [31:0]      o_s_addr,
    output logic [31:0]      o_s_wdata,
    output logic [3:0]       o_s_be,
    input  logic [31:0]      i_s_rdata,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_m0_stall_cnt,
    output logic [CNT_W-1:0] o_m1_stall_cnt
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_e;

    localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

    state_e     state_q, state_d;
    logic [2:0] lat_cnt_q, lat_cnt_d;
    logic       rd_owner_q, rd_owner_d;
    logic       last_gnt_q, last_gnt_d;

    logic       can_grant_s;
    logic       rd_done_s;
    logic       gnt0_s, gnt1_s, any_gnt_s, gnt_we_s;

    // Arbitration; grants are suppressed while reset is asserted so all outputs read 0.
    always_comb begin
        gnt0_s      = 1'b0;
        gnt1_s      = 1'b0;
        rd_done_s   = (state_q == RD_WAIT) && (lat_cnt_q == 3'd1);
        can_grant_s = (state_q == IDLE) || rd_done_s;
        if (can_grant_s && i_rst_n) begin
            if (i_m0_req && i_m1_req) begin
                gnt0_s = last_gnt_q;
                gnt1_s = ~last_gnt_q;
            end else begin
                gnt0_s = i_m0_req;
                gnt1_s = i_m1_req;
            end
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    assign any_gnt_s = gnt0_s | gnt1_s;
    assign gnt_we_s  = gnt1_s ? i_m1_we : i_m0_we;

    // Downstream command mux and read-return routing.
    always_comb begin
        o_m0_gnt    = gnt0_s;
        o_m1_gnt    = gnt1_s;
        o_s_we      = any_gnt_s & gnt_we_s;
        o_s_re      = any_gnt_s & ~gnt_we_s;
        o_s_addr    = 32'h0000_0000;
        o_s_wdata   = 32'h0000_0000;
        o_s_be      = 4'h0;
        if (gnt1_s) begin
            o_s_addr  = i_m1_addr;
            o_s_wdata = i_m1_wdata;
            o_s_be    = i_m1_be;
        end else if (gnt0_s) begin
            o_s_addr  = i_m0_addr;
            o_s_wdata = i_m0_wdata;
            o_s_be    = i_m0_be;
        end else begin
            o_s_addr  = 32'h0000_0000;
            o_s_wdata = 32'h0000_0000;
            o_s_be    = 4'h0;
        end
        o_m0_rvalid = rd_done_s & ~rd_owner_q;
        o_m1_rvalid = rd_done_s & rd_owner_q;
        o_m0_rdata  = o_m0_rvalid ? i_s_rdata : 32'h0000_0000;
        o_m1_rdata  = o_m1_rvalid ? i_s_rdata : 32'h0000_0000;
        o_busy      = (state_q == RD_WAIT);
    end

    // Next-state logic; a read granted on the last wait cycle reloads RD_WAIT.
    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        rd_owner_d = rd_owner_q;
        last_gnt_d = last_gnt_q;
        case (state_q)
            IDLE: begin
                state_d   = IDLE;
                lat_cnt_d = 3'd0;
            end
            RD_WAIT: begin
                lat_cnt_d = lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    state_d = IDLE;
                end else begin
                    state_d = RD_WAIT;
                end
            end
            default: begin
                state_d   = IDLE;
                lat_cnt_d = 3'd0;
            end
        endcase
        if (any_gnt_s) begin
            last_gnt_d = gnt1_s;
            if (!gnt_we_s) begin
                state_d    = RD_WAIT;
                lat_cnt_d  = LAT_INIT;
                rd_owner_d = gnt1_s;
            end else begin
                rd_owner_d = rd_owner_q;
            end
        end else begin
            last_gnt_d = last_gnt_q;
        end
    end

    // FSM and arbitration state registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            lat_cnt_q  <= 3'd0;
            rd_owner_q <= 1'b0;
            last_gnt_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            lat_cnt_q  <= lat_cnt_d;
            rd_owner_q <= rd_owner_d;
            last_gnt_q <= last_gnt_d;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        if (en && (cnt != CNT_MAX)) begin
            sat_inc = cnt + CNT_ONE;
        end else begin
            sat_inc = cnt;
        end
    endfunction

    logic [CNT_W-1:0] m0_cnt_q, m0_cnt_d;
    logic [CNT_W-1:0] m1_cnt_q, m1_cnt_d;

    // Saturating stall counters: request pending but not granted.
    always_comb begin
        m0_cnt_d = sat_inc(m0_cnt_q, i_m0_req & ~gnt0_s);
        m1_cnt_d = sat_inc(m1_cnt_q, i_m1_req & ~gnt1_s);
    end

    // Stall counter registers, cleared only by reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m0_cnt_q <= {CNT_W{1'b0}};
            m1_cnt_q <= {CNT_W{1'b0}};
        end else begin
            m0_cnt_q <= m0_cnt_d;
            m1_cnt_q <= m1_cnt_d;
        end
    end

    assign o_m0_stall_cnt = m0_cnt_q;
    assign o_m1_stall_cnt = m1_cnt_q;
`else
    assign o_m0_stall_cnt = {CNT_W{1'b0}};
    assign o_m1_stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: three instances (RD_LAT 1, 2, 4; the last with 4-bit counters)
// share one stimulus set, and each scenario checks the instance whose latency it targets.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_be, m1_be;

    logic        m0_gnt [3];
    logic        m1_gnt [3];
    logic        m0_rv  [3];
    logic        m1_rv  [3];
    logic        s_re   [3];
    logic        s_we   [3];
    logic        busy   [3];
    logic [31:0] m0_rd  [3];
    logic [31:0] m1_rd  [3];
    logic [31:0] s_addr [3];
    logic [31:0] s_wdat [3];
    logic [3:0]  s_be   [3];
    logic [15:0] c0     [3];
    logic [15:0] c1     [3];

    int n_checks = 0;
    int n_err    = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int CW  = (g == 2) ? 4 : 16;
        logic [CW-1:0] c0_s, c1_s;
        dmem_arbiter #(.RD_LAT(LAT), .CNT_W(CW)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n),
            .i_m0_req(m0_req), .i_m1_req(m1_req),
            .i_m0_we(m0_we), .i_m1_we(m1_we),
            .i_m0_addr(m0_addr), .i_m1_addr(m1_addr),
            .i_m0_wdata(m0_wdata), .i_m1_wdata(m1_wdata),
            .i_m0_be(m0_be), .i_m1_be(m1_be),
            .o_m0_gnt(m0_gnt[g]), .o_m1_gnt(m1_gnt[g]),
            .o_m0_rvalid(m0_rv[g]), .o_m1_rvalid(m1_rv[g]),
            .o_m0_rdata(m0_rd[g]), .o_m1_rdata(m1_rd[g]),
            .o_s_re(s_re[g]), .o_s_we(s_we[g]),
            .o_s_addr(s_addr[g]), .o_s_wdata(s_wdat[g]), .o_s_be(s_be[g]),
            .i_s_rdata(s_rdata), .o_busy(busy[g]),
            .o_m0_stall_cnt(c0_s), .o_m1_stall_cnt(c1_s)
        );
        assign c0[g] = 16'(c0_s);
        assign c1[g] = 16'(c1_s);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        m0_addr = 32'h0; m1_addr = 32'h0; m0_wdata = 32'h0; m1_wdata = 32'h0;
        m0_be = 4'hF; m1_be = 4'hF; s_rdata = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        logic seen;
        int   g0, g1;

        // Reset state with a live request
        idle();
        rst_n = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h55;
        tick();
        @(negedge clk);
        check("rst_gnt", 32'(m0_gnt[1]), 32'd0);
        check("rst_s_re", 32'(s_re[1]), 32'd0);
        check("rst_s_addr", s_addr[1], 32'h0);
        check("rst_busy", 32'(busy[1]), 32'd0);
        check("rst_cnt0", 32'(c0[1]), 32'd0);
        tick();
        rst_n = 1'b1;
        idle();

        // Reset mid-read on the RD_LAT=4 instance
        m0_req = 1'b1; m0_addr = 32'h20;
        @(negedge clk);
        check("mid_gnt", 32'(m0_gnt[2]), 32'd1);
        check("mid_s_re", 32'(s_re[2]), 32'd1);
        tick();
        idle();
        rst_n = 1'b0;
        m0_req = 1'b1; m0_addr = 32'h30;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy[2]), 32'd0);
        check("mid_rst_gnt", 32'(m0_gnt[2]), 32'd0);
        check("mid_rst_s_re", 32'(s_re[2]), 32'd0);
        check("mid_rst_s_addr", s_addr[2], 32'h0);
        tick();
        rst_n = 1'b1;
        idle();
        s_rdata = 32'hBAD0_BAD0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            seen = seen | m0_rv[2] | busy[2];
            tick();
        end
        check("mid_no_rvalid", 32'(seen), 32'd0);
        m0_req = 1'b1; m0_addr = 32'h10;
        @(negedge clk);
        check("mid_regrant", 32'(m0_gnt[2]), 32'd1);
        check("mid_regrant_addr", s_addr[2], 32'h10);
        tick();

        // Single read, RD_LAT=2
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h0000_0100; m0_be = 4'h6;
        @(negedge clk);
        check("rd_gnt", 32'(m0_gnt[1]), 32'd1);
        check("rd_s_re", 32'(s_re[1]), 32'd1);
        check("rd_s_addr", s_addr[1], 32'h0000_0100);
        check("rd_s_be", 32'(s_be[1]), 32'h6);
        check("rd_busy_c0", 32'(busy[1]), 32'd0);
        tick();
        idle();
        @(negedge clk);
        check("rd_busy_c1", 32'(busy[1]), 32'd1);
        check("rd_rv_c1", 32'(m0_rv[1]), 32'd0);
        tick();
        s_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check("rd_rv_c2", 32'(m0_rv[1]), 32'd1);
        check("rd_data_c2", m0_rd[1], 32'hDEAD_BEEF);
        check("rd_m1rv_c2", 32'(m1_rv[1]), 32'd0);
        check("rd_busy_c2", 32'(busy[1]), 32'd1);
        tick();
        @(negedge clk);
        check("rd_busy_c3", 32'(busy[1]), 32'd0);
        check("rd_data_c3", m0_rd[1], 32'h0);
        tick();

        // Tie, round-robin writes on RD_LAT=1 instance
        do_reset();
        for (int i = 0; i < 4; i++) begin
            m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'hA0; m0_wdata = 32'h100 + 32'(i);
            m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'hB0; m1_wdata = 32'h200 + 32'(i);
            @(negedge clk);
            check($sformatf("rr_m0_gnt%0d", i), 32'(m0_gnt[0]), ((i % 2) == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr_m1_gnt%0d", i), 32'(m1_gnt[0]), ((i % 2) == 1) ? 32'd1 : 32'd0);
            check($sformatf("rr_wdata%0d", i), s_wdat[0],
                  ((i % 2) == 0) ? (32'h100 + 32'(i)) : (32'h200 + 32'(i)));
            check($sformatf("rr_s_we%0d", i), 32'(s_we[0]), 32'd1);
            tick();
        end
        idle();
        @(negedge clk);
        check("rr_cnt0", 32'(c0[0]), PERF ? 32'd2 : 32'd0);
        check("rr_cnt1", 32'(c1[0]), PERF ? 32'd2 : 32'd0);
        tick();

        // Read/write overlap, RD_LAT=1
        do_reset();
        m1_req = 1'b1; m1_addr = 32'h40;
        @(negedge clk);
        check("ov_m1_gnt", 32'(m1_gnt[0]), 32'd1);
        check("ov_s_re", 32'(s_re[0]), 32'd1);
        tick();
        idle();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h44; m0_wdata = 32'hCAFE;
        s_rdata = 32'h1234_5678;
        @(negedge clk);
        check("ov_m0_gnt", 32'(m0_gnt[0]), 32'd1);
        check("ov_m1_rv", 32'(m1_rv[0]), 32'd1);
        check("ov_m1_rd", m1_rd[0], 32'h1234_5678);
        check("ov_m0_rv", 32'(m0_rv[0]), 32'd0);
        check("ov_s_we", 32'(s_we[0]), 32'd1);
        check("ov_s_wdata", s_wdat[0], 32'hCAFE);
        tick();
        idle();
        @(negedge clk);
        check("ov_busy_end", 32'(busy[0]), 32'd0);
        check("ov_m0_rv_end", 32'(m0_rv[0]), 32'd0);
        tick();

        // Blocked during RD_WAIT, RD_LAT=4
        do_reset();
        m0_req = 1'b1; m0_addr = 32'h200;
        tick();
        idle();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h300;
        seen = 1'b0;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            seen = seen | m1_gnt[2];
            tick();
        end
        check("blk_early_gnt", 32'(seen), 32'd0);
        @(negedge clk);
        check("blk_gnt_c4", 32'(m1_gnt[2]), 32'd1);
        check("blk_rv_c4", 32'(m0_rv[2]), 32'd1);
        tick();
        idle();
        @(negedge clk);
        check("blk_cnt1", 32'(c1[2]), PERF ? 32'd3 : 32'd0);
        check("blk_cnt0", 32'(c0[2]), 32'd0);
        tick();

        // Saturation: m0 streams reads, m1 streams writes, 30 cycles
        do_reset();
        g0 = 0; g1 = 0;
        for (int i = 0; i < 30; i++) begin
            m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h400;
            m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h500;
            @(negedge clk);
            g0 += int'(m0_gnt[2]);
            g1 += int'(m1_gnt[2]);
            tick();
        end
        idle();
        @(negedge clk);
        check("sat_m0_grants", 32'(g0), 32'd6);
        check("sat_m1_grants", 32'(g1), 32'd6);
        check("sat_cnt1", 32'(c1[2]), PERF ? 32'd15 : 32'd0);
        check("sat_cnt0", 32'(c0[2]), PERF ? 32'd15 : 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
